adau_config_seq: RTL and testbench

ADAU_CONFIG_SEQ -- requirements
Module: adau_config_seq

---
 rtl/adau_config_seq.sv | 204 ++++++++++++++++++++
 tb/tb_adau_config_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adau_config_seq.sv
// ADAU codec configuration sequencer: walks a register table over an I2C
// command channel, polls PLL lock partway through, then ungates the serdes.
module adau_config_seq #(
  parameter int          NUM_WRITES     = 16,
  parameter int          PLL_WRITES     = 2,
  parameter logic [6:0]  DEV_ADDR       = 7'h3B,
  parameter logic [15:0] POLL_REG       = 16'h4007,
  parameter int          LOCK_BIT       = 1,
  parameter int          POLL_LIMIT     = 1024,
  parameter int          RETRY_LIMIT    = 3,
  parameter int          STARTUP_CYCLES = 4096,
  localparam int AW = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [23:0]   rom_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_rw,
  output logic [6:0]    cmd_dev,
  output logic [15:0]   cmd_reg,
  output logic [7:0]    cmd_wdata,
  input  logic          rsp_valid,
  input  logic          rsp_nack,
  input  logic [7:0]    rsp_rdata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          serdes_enable
);

  localparam int DW = $clog2(STARTUP_CYCLES + 1);
  localparam int RW = $clog2(RETRY_LIMIT + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);

  localparam logic [AW-1:0] LAST  = AW'(NUM_WRITES - 1);
  localparam logic [AW-1:0] PLLI  = AW'(PLL_WRITES);
  localparam logic [DW-1:0] DLAST = DW'(STARTUP_CYCLES - 1);
  localparam logic [RW-1:0] RMAX  = RW'(RETRY_LIMIT);
  localparam logic [PW-1:0] PMAX  = PW'(POLL_LIMIT);

  typedef enum logic [3:0] {
    IDLE,
    DELAY,
    FETCH,
    ISSUE,
    WAIT_RSP,
    POLL_ISSUE,
    POLL_WAIT,
    DONE,
    ERROR
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   r_rom_addr;
  logic [DW-1:0]   r_dly;
  logic [RW-1:0]   r_retry;
  logic [PW-1:0]   r_poll;
  logic            r_cmd_valid;
  logic            r_cmd_rw;
  logic [15:0]     r_cmd_reg;
  logic [7:0]      r_cmd_wdata;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic            r_serdes;
  logic            w_unused;

  assign rom_addr      = r_rom_addr;
  assign cmd_valid     = r_cmd_valid;
  assign cmd_rw        = r_cmd_rw;
  assign cmd_dev       = DEV_ADDR;
  assign cmd_reg       = r_cmd_reg;
  assign cmd_wdata     = r_cmd_wdata;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign serdes_enable = r_serdes;
  assign w_unused      = ^rsp_rdata;

  // State change plus the status flags that belong to the state being entered
  task automatic go(input state_t s);
    r_state     <= s;
    r_busy      <= !(s == IDLE || s == DONE || s == ERROR);
    r_done      <= (s == DONE);
    r_serdes    <= (s == DONE);
    r_error     <= (s == ERROR);
    r_cmd_valid <= (s == ISSUE) || (s == POLL_ISSUE);
    r_cmd_rw    <= (s == POLL_ISSUE);
  endtask

  // Sequencer FSM; rom_addr runs one entry ahead once a write is accepted
  // so a registered table has settled by the time FETCH samples it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_rom_addr  <= '0;
      r_dly       <= '0;
      r_retry     <= '0;
      r_poll      <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_rw    <= 1'b0;
      r_cmd_reg   <= '0;
      r_cmd_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_serdes    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_idx      <= '0;
            r_rom_addr <= '0;
            r_dly      <= '0;
            r_retry    <= '0;
            r_poll     <= '0;
            go(DELAY);
          end
        end
        DELAY: begin
          if (r_dly == DLAST) begin
            go(FETCH);
          end else begin
            r_dly <= r_dly + DW'(1);
          end
        end
        FETCH: begin
          r_cmd_reg   <= rom_data[23:8];
          r_cmd_wdata <= rom_data[7:0];
          go(ISSUE);
        end
        ISSUE: begin
          if (cmd_ready) begin
            if (r_idx != LAST) begin
              r_rom_addr <= r_idx + AW'(1);
            end
            go(WAIT_RSP);
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_nack) begin
              if (r_retry < RMAX) begin
                r_retry <= r_retry + RW'(1);
                go(ISSUE);
              end else begin
                go(ERROR);
              end
            end else begin
              r_retry <= '0;
              if (r_idx == LAST) begin
                go(DONE);
              end else begin
                r_idx <= r_idx + AW'(1);
                if (r_idx + AW'(1) == PLLI) begin
                  r_cmd_reg   <= POLL_REG;
                  r_cmd_wdata <= '0;
                  go(POLL_ISSUE);
                end else begin
                  go(FETCH);
                end
              end
            end
          end
        end
        POLL_ISSUE: begin
          if (cmd_ready) begin
            go(POLL_WAIT);
          end
        end
        POLL_WAIT: begin
          if (rsp_valid) begin
            if (rsp_nack) begin
              if (r_retry < RMAX) begin
                r_retry <= r_retry + RW'(1);
                go(POLL_ISSUE);
              end else begin
                go(ERROR);
              end
            end else begin
              r_retry <= '0;
              if (rsp_rdata[LOCK_BIT]) begin
                go(FETCH);
              end else if (r_poll == PMAX - PW'(1)) begin
                r_poll <= PMAX;
                go(ERROR);
              end else begin
                r_poll <= r_poll + PW'(1);
                go(POLL_ISSUE);
              end
            end
          end
        end
        default: go(IDLE);
      endcase
    end
  end

endmodule

// File: tb/tb_adau_config_seq.sv
// Bench for adau_config_seq: I2C slave + registered table model, command
// sequence predicted from scenario rules and checked at every handshake.
module tb_adau_config_seq;

  localparam int NW = 4;
  localparam int PLLW = 2;
  localparam int RL = 3;
  localparam int PL = 5;
  localparam int SC = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_rw;
  logic [6:0]  cmd_dev;
  logic [15:0] cmd_reg;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid = 1'b0;
  logic        rsp_nack = 1'b0;
  logic [7:0]  rsp_rdata = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic        serdes_enable;

  adau_config_seq #(
    .NUM_WRITES(NW),
    .PLL_WRITES(PLLW),
    .DEV_ADDR(7'h3B),
    .POLL_REG(16'h4007),
    .LOCK_BIT(1),
    .POLL_LIMIT(PL),
    .RETRY_LIMIT(RL),
    .STARTUP_CYCLES(SC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_nack(rsp_nack),
    .rsp_rdata(rsp_rdata),
    .busy(busy),
    .done(done),
    .error(error),
    .serdes_enable(serdes_enable)
  );

  always #5 clk = ~clk;

  logic [23:0] tbl [NW] = '{24'h4000_01, 24'h4002_7D, 24'h4015_01, 24'h4019_63};

  always @(posedge clk) rom_data <= tbl[rom_addr];

  typedef struct packed {
    logic        rw;
    logic [15:0] rg;
    logic [7:0]  wd;
  } txn_t;

  txn_t exp_q[$];
  int   sc_nack [NW];
  int   sc_unlock;
  bit   exp_err;
  int   att [NW];
  int   rd_cnt;
  int   hs_cnt;
  int   stall_cnt;
  int   bp_left = 0;
  int   lat = 1;
  int   pend = 0;
  logic pend_nack;
  logic [7:0] pend_rd;
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  logic prev_rstn = 1'b0;
  logic [24:0] prev_cmd = '0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endfunction

  // Expected command stream from the scenario rules
  function automatic void model_build();
    int   nrd;
    int   na;
    txn_t t;
    exp_q.delete();
    exp_err = 1'b0;
    for (int e = 0; e < NW; e++) begin
      if (e == PLLW) begin
        if (sc_unlock < 0 || sc_unlock >= PL) nrd = PL;
        else nrd = sc_unlock + 1;
        t.rw = 1'b1;
        t.rg = 16'h4007;
        t.wd = 8'h00;
        for (int k = 0; k < nrd; k++) exp_q.push_back(t);
        if (sc_unlock < 0 || sc_unlock >= PL) begin
          exp_err = 1'b1;
          return;
        end
      end
      na = (sc_nack[e] > RL) ? RL + 1 : sc_nack[e] + 1;
      t.rw = 1'b0;
      t.rg = tbl[e][23:8];
      t.wd = tbl[e][7:0];
      for (int k = 0; k < na; k++) exp_q.push_back(t);
      if (sc_nack[e] > RL) begin
        exp_err = 1'b1;
        return;
      end
    end
  endfunction

  // Slave responder and the single per-cycle compare process
  always @(negedge clk) begin
    logic hs;
    txn_t got;
    txn_t want;
    if (reset_n && prev_rstn) begin
      chk("cmd_dev", 32'(cmd_dev), 32'h3B);
      chk("valid_needs_busy", 32'(cmd_valid && !busy), 32'd0);
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", 32'(cmd_valid), 32'd1);
        chk("hold_cmd", 32'({cmd_rw, cmd_reg, cmd_wdata}), 32'(prev_cmd));
      end
    end
    if (rsp_valid) begin
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      rsp_rdata = '0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        rsp_valid = 1'b1;
        rsp_nack  = pend_nack;
        rsp_rdata = pend_rd;
      end
    end
    if (cmd_valid && bp_left > 0) begin
      bp_left--;
      cmd_ready = 1'b0;
    end else begin
      cmd_ready = 1'b1;
    end
    if (cmd_valid && !cmd_ready) stall_cnt++;
    hs = cmd_valid && cmd_ready && reset_n;
    if (hs) begin
      got.rw = cmd_rw;
      got.rg = cmd_reg;
      got.wd = cmd_wdata;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_cmd: got %0h want none", got);
      end else begin
        want = exp_q.pop_front();
        chk($sformatf("hs%0d", hs_cnt), 32'(got), 32'(want));
      end
      hs_cnt++;
      pend_nack = 1'b0;
      pend_rd   = 8'h00;
      if (cmd_rw) begin
        if (sc_unlock >= 0 && rd_cnt >= sc_unlock) pend_rd = 8'h02;
        rd_cnt++;
      end else begin
        for (int e = 0; e < NW; e++) begin
          if (tbl[e][23:8] == cmd_reg) begin
            pend_nack = (att[e] < sc_nack[e]);
            att[e]++;
          end
        end
      end
      pend = lat;
    end
    prev_valid = cmd_valid;
    prev_hs    = hs;
    prev_cmd   = {cmd_rw, cmd_reg, cmd_wdata};
    prev_rstn  = reset_n;
  end

  task automatic setup(input int n0, input int n1, input int n2, input int n3,
                       input int unl, input int bp);
    sc_nack   = '{n0, n1, n2, n3};
    sc_unlock = unl;
    bp_left   = bp;
    lat       = 1;
    att       = '{default: 0};
    rd_cnt    = 0;
    hs_cnt    = 0;
    stall_cnt = 0;
    model_build();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic start_run(input string nm);
    int n;
    pulse_start();
    chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({nm, "_rom_addr0"}, 32'(rom_addr), 32'd0);
    n = 0;
    while (!cmd_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk({nm, "_first_valid_lat"}, 32'(n), 32'(SC + 1));
  endtask

  task automatic finish_run(input string nm, input int want_hs);
    int n;
    n = 0;
    while (!(done || error) && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no end want done/error", nm);
    end
    chk({nm, "_done"}, 32'(done), 32'(!exp_err));
    chk({nm, "_serdes"}, 32'(serdes_enable), 32'(!exp_err));
    chk({nm, "_error"}, 32'(error), 32'(exp_err));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_hs_count"}, 32'(hs_cnt), 32'(want_hs));
    chk({nm, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run(input string nm, input int n0, input int n1, input int n2,
                     input int n3, input int unl, input int bp, input int want_hs,
                     input bit want_err);
    setup(n0, n1, n2, n3, unl, bp);
    chk({nm, "_model_len"}, 32'(exp_q.size()), 32'(want_hs));
    chk({nm, "_model_err"}, 32'(exp_err), 32'(want_err));
    start_run(nm);
    finish_run(nm, want_hs);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_error"}, 32'(error), 32'd0);
    chk({nm, "_serdes"}, 32'(serdes_enable), 32'd0);
    chk({nm, "_rom_addr"}, 32'(rom_addr), 32'd0);
  endtask

  initial begin
    int n;
    #2 reset_n = 1'b0;
    #1 chk_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("post_reset");

    run("nominal", 0, 0, 0, 0, 0, 0, 5, 1'b0);
    run("retry", 0, 2, 0, 0, 0, 0, 7, 1'b0);
    run("exhaust", 99, 0, 0, 0, 0, 0, 4, 1'b1);
    run("poll_to", 0, 0, 0, 0, -1, 0, 7, 1'b1);
    run("bp", 0, 0, 0, 0, 0, 10, 5, 1'b0);
    chk("bp_stall_cycles", 32'(stall_cnt), 32'd10);

    setup(0, 0, 0, 0, 0, 0);
    lat = 3;
    start_run("rst");
    n = 0;
    while (hs_cnt < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_entry2", 32'(hs_cnt), 32'd4);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_idle_outputs("rst_mid");
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk_idle_outputs("rst_stale_rsp");

    setup(0, 0, 0, 0, 0, 0);
    start_run("restart");
    n = 0;
    while (hs_cnt < 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    pulse_start();
    finish_run("restart", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
